// File: rtl/mem_pkg.sv
// Shared types and helpers for the Harvard core's memory-side responders.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} ram_state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    function automatic logic [31:0] lane_mask(input logic [WORD_BYTES-1:0] byteenable);
        logic [31:0] m;
        for (int i = 0; i < WORD_BYTES; i++) begin
            m[8*i +: 8] = {8{byteenable[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational per-lane merge of store data into an existing word.
module byte_merge
    import mem_pkg::*;
(
    input  logic [31:0]           old_word,
    input  logic [31:0]           new_word,
    input  logic [WORD_BYTES-1:0] byteenable,
    output logic [31:0]           merged
);

    logic [31:0] mask;

    assign mask   = lane_mask(byteenable);
    assign merged = (old_word & ~mask) | (new_word & mask);

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder with wait states and a waitrequest handshake.
// Optional alignment/conflict fault reporting: DATA_RAM_ALIGN_CHECK_EN.
module data_ram_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [WORD_BYTES-1:0] byteenable,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  waitrequest,
    output logic                  error
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [32:0]      SPAN      = 33'(WORD_BYTES) << ADDR_WIDTH;

    ram_state_t state, state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic [31:0]           cap_addr;
    logic [31:0]           cap_wdata;
    logic [WORD_BYTES-1:0] cap_be;
    logic                  cap_rd;
    logic                  cap_wr;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic                  req;
    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fault;
    logic [31:0]           old_word;
    logic [31:0]           merged;
    logic                  commit;

    assign req      = read | write;
    assign offset   = cap_addr - BASE_ADDR;
    assign in_range = (cap_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign idx      = offset[ADDR_WIDTH+1:2];
    assign old_word = mem[idx];

`ifdef DATA_RAM_ALIGN_CHECK_EN
    assign fault = (cap_addr[1:0] != 2'b00) || (cap_rd && cap_wr);
`else
    assign fault = 1'b0;
`endif

    byte_merge u_merge (
        .old_word   (old_word),
        .new_word   (cap_wdata),
        .byteenable (cap_be),
        .merged     (merged)
    );

    // Reset in the ACK cycle must still suppress the commit.
    assign commit = (state == ACK) && cap_wr && in_range && !fault && !reset;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        waitrequest = 1'b0;
        readdata    = 32'h0;
        error       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    waitrequest = 1'b1;
                    state_nxt   = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                waitrequest = 1'b1;
                if (!req)               state_nxt = IDLE;
                else if (cnt <= 4'd1)   state_nxt = ACK;
            end
            ACK: begin
                state_nxt = IDLE;
                error     = fault;
                if (cap_rd && !cap_wr && in_range && !fault) readdata = old_word;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt       <= WAIT_INIT;
                        cap_addr  <= address;
                        cap_wdata <= writedata;
                        cap_be    <= byteenable;
                        cap_rd    <= read;
                        cap_wr    <= write;
                    end
                end
                WAIT: begin
                    if (cnt != '0) cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= merged;
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized scoreboard bench for data_ram_responder against a word-array model.
module tb_data_ram_responder;

    localparam int          W    = 1;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest, error;
    logic [3:0]  byteenable;

    logic        z_reset;
    logic [31:0] z_address, z_writedata, z_readdata;
    logic        z_read, z_write, z_waitrequest, z_error;
    logic [3:0]  z_byteenable;

    always #5 clk = ~clk;

    data_ram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .error(error)
    );

    data_ram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(z_reset), .address(z_address), .read(z_read), .write(z_write),
        .byteenable(z_byteenable), .writedata(z_writedata), .readdata(z_readdata),
        .waitrequest(z_waitrequest), .error(z_error)
    );

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_cnt = 0;
    bit          mon_en = 1'b0;
    logic [31:0] mdl [0:1023];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the RAM is an array of words; a store overwrites the enabled bytes.
    task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        logic inr;
        logic flt;
        int   idx;
        inr = (a >= BASE) && (a < BASE + 32'd4096);
        idx = int'((a - BASE) >> 2);
        flt = 1'b0;
`ifdef DATA_RAM_ALIGN_CHECK_EN
        flt = (a[1:0] != 2'b00) || (rd && wr);
`endif
        e.stalls   = W + 1;
        e.err      = flt;
        e.chk_data = rd;
        e.data     = 32'h0;
        if (wr) begin
            if (inr && !flt)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
        end else if (inr && !flt) begin
            e.data = mdl[idx];
        end
        sbq.push_back(e);
    endtask

    // Entered and left just after a rising edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        int t;
        t = 0;
        model_access(rd, wr, a, be, wd);
        read = rd; write = wr; address = a; byteenable = be; writedata = wd;
        do begin
            @(negedge clk);
            t++;
        end while (waitrequest && t < 50);
        if (waitrequest) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no ack for address %h after %0d cycles", a, t);
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && (read || write)) begin
            if (waitrequest) begin
                stall_cnt++;
            end else begin
                exp_t e;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: got ack with empty scoreboard");
                end else begin
                    e = sbq.pop_front();
                    check("stall_cycles", stall_cnt, e.stalls);
                    check("error", {31'b0, error}, {31'b0, e.err});
                    if (e.chk_data) check("readdata", readdata, e.data);
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  pat;
        logic [31:0] a;
        int          k, op;
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; byteenable = '0; writedata = '0;
        z_reset = 1'b1; z_read = 1'b0; z_write = 1'b0; z_address = '0; z_byteenable = '0; z_writedata = '0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; z_reset = 1'b0;
        @(negedge clk);
        check("reset_waitrequest", {31'b0, waitrequest}, 32'h0);
        check("reset_error", {31'b0, error}, 32'h0);
        check("reset_readdata", readdata, 32'h0);
        check("reset_z_waitrequest", {31'b0, z_waitrequest}, 32'h0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) access(1'b0, 1'b1, BASE + 32'(4*i), 4'hF, $urandom);
        access(1'b0, 1'b1, BASE + 32'(4*1023), 4'hF, $urandom);

        access(1'b0, 1'b1, BASE, 4'hF, 32'hDEADBEEF);
        access(1'b1, 1'b0, BASE, 4'hF, 32'h0);
        access(1'b0, 1'b1, BASE, 4'b0010, 32'h0000AA00);
        access(1'b1, 1'b0, BASE, 4'hF, 32'h0);
        check("merge_model", mdl[0], 32'hDEADAAEF);
        access(1'b1, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0);
        access(1'b0, 1'b1, 32'h0000_2000, 4'hF, 32'h5555_5555);
        access(1'b1, 1'b0, 32'h0000_1FFC, 4'hF, 32'h0);
        access(1'b1, 1'b0, 32'h0000_1002, 4'hF, 32'h0);
        access(1'b1, 1'b1, 32'h0000_1008, 4'hF, 32'h0BAD_0BAD);
        access(1'b1, 1'b0, 32'h0000_1008, 4'hF, 32'h0);

        // Reset during WAIT of a store: the store must not land.
        mon_en = 1'b0;
        write = 1'b1; address = BASE; byteenable = 4'hF; writedata = 32'h12345678;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; write = 1'b0;
        @(negedge clk);
        check("reset_abort_error", {31'b0, error}, 32'h0);
        @(posedge clk); #1;
        stall_cnt = 0; mon_en = 1'b1;
        access(1'b1, 1'b0, BASE, 4'hF, 32'h0);

        // Store withdrawn during WAIT: nothing committed.
        mon_en = 1'b0;
        write = 1'b1; address = BASE + 32'd4; byteenable = 4'hF; writedata = 32'hCAFEF00D;
        @(posedge clk); #1; write = 1'b0;
        repeat (2) @(posedge clk);
        #1; stall_cnt = 0; mon_en = 1'b1;
        access(1'b1, 1'b0, BASE + 32'd4, 4'hF, 32'h0);

        repeat (200) begin
            k = $urandom_range(0, 19);
            if (k < 17) begin
                a = BASE + 32'(4 * ((k == 16) ? 1023 : $urandom_range(0, 15)));
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            end else begin
                a = (k == 17) ? 32'h0000_0FFC : (k == 18) ? 32'h0000_2000 : 32'hFFFF_FFFC;
            end
            op = $urandom_range(0, 9);
            access((op < 5) || (op == 9), op >= 5, a, 4'($urandom), $urandom);
        end
        mon_en = 1'b0;
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);

        // Zero wait states: store, then back-to-back loads with one idle gap.
        z_write = 1'b1; z_address = BASE; z_byteenable = 4'hF; z_writedata = 32'h11223344;
        @(negedge clk);
        check("z_write_wreq0", {31'b0, z_waitrequest}, 32'h1);
        @(negedge clk);
        check("z_write_ack", {31'b0, z_waitrequest}, 32'h0);
        @(posedge clk); #1;
        z_write = 1'b0; z_read = 1'b1;
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("z_read_wreq%0d", i), {31'b0, z_waitrequest}, {31'b0, pat[i]});
            if (pat[i] == 1'b0) begin
                check($sformatf("z_readdata%0d", i), z_readdata, 32'h11223344);
                check($sformatf("z_error%0d", i), {31'b0, z_error}, 32'h0);
            end
        end
        @(posedge clk); #1; z_read = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
